// File: rtl/change_pkg.sv
// Shared types for the bit-serial sign-change unit: operation modes,
// controller states and the mode field width.
package change_pkg;

    localparam int CHANGE_MODE_W = 2;

    typedef enum logic [CHANGE_MODE_W-1:0] {
        MODE_PASS  = 2'b00,
        MODE_NEG   = 2'b01,
        MODE_ABS   = 2'b10,
        MODE_SM2TC = 2'b11
    } change_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } change_state_e;

endpackage

// File: rtl/change_seq_if.sv
// Operand/result handshake bundle for change_seq; the unit itself uses the
// slave modport, the producer/consumer side uses master.
interface change_seq_if #(
    parameter int NUM = 8
);
    import change_pkg::*;

    logic                     i_valid;
    logic                     o_ready;
    logic [NUM-1:0]           i_argA;
    logic [CHANGE_MODE_W-1:0] i_mode;
    logic                     o_valid;
    logic                     i_ready;
    logic [NUM-1:0]           o_result;
    logic                     o_ovf;

    modport slave (
        input  i_valid, i_argA, i_mode, i_ready,
        output o_ready, o_valid, o_result, o_ovf
    );

    modport master (
        output i_valid, i_argA, i_mode, i_ready,
        input  o_ready, o_valid, o_result, o_ovf
    );

endinterface

// File: rtl/change_serial_cell.sv
// One-bit serial two's complement negator: passes bits through up to and
// including the first 1, then inverts the rest while negation is enabled.
module change_serial_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clr_i,
    input  logic step_i,
    input  logic bit_i,
    input  logic neg_en_i,
    output logic bit_o
);

    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clr_i) begin
            seen_one_d = 1'b0;
        end else if (step_i) begin
            seen_one_d = seen_one_q | bit_i;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

    assign bit_o = bit_i ^ (neg_en_i & seen_one_q);

endmodule

// File: rtl/change_seq.sv
// Bit-serial PASS/NEG/ABS/SM2TC unit, one bit per clock, LSB first.
// Define CHANGE_SEQ_SAT_EN to saturate the overflow result to the most positive value.
module change_seq
    import change_pkg::*;
#(
    parameter int NUM = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    change_seq_if.slave bus
);

    localparam int             CNT_W    = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);
    localparam logic [NUM-1:0] MIN_NEG  = {1'b1, {(NUM-1){1'b0}}};

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

`ifdef CHANGE_SEQ_SAT_EN
    function automatic logic [NUM-1:0] sat_result(input logic [NUM-1:0] raw,
                                                  input logic           ovf);
        sat_result = ovf ? {1'b0, {(NUM-1){1'b1}}} : raw;
    endfunction
`endif

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [NUM-1:0]   op_q,       op_d;
    logic [NUM-1:0]   sr_q,       sr_d;
    logic             neg_q,      neg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             ready_q,    ready_d;
    logic             valid_q,    valid_d;
    logic [NUM-1:0]   res_q,      res_d;
    logic             ovf_q,      ovf_d;

    logic             accept;
    logic             step;
    logic             cell_bit;
    logic             arg_msb;
    logic             dec_neg;
    logic             dec_ovf;
    logic [NUM-1:0]   dec_op;
    logic [NUM-1:0]   full_res;

    assign accept = (state_q == S_IDLE) && ready_q && bus.i_valid;
    assign step   = (state_q == S_RUN);

    change_serial_cell u_cell (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .clr_i    (accept),
        .step_i   (step),
        .bit_i    (op_q[0]),
        .neg_en_i (neg_q),
        .bit_o    (cell_bit)
    );

    // The whole operation collapses to copy-or-negate at accept time; SM2TC
    // strips the sign so only the magnitude is negated.
    always_comb begin
        arg_msb = bus.i_argA[NUM-1];
        dec_op  = bus.i_argA;
        dec_neg = 1'b0;
        dec_ovf = 1'b0;
        case (change_mode_e'(bus.i_mode))
            MODE_NEG: begin
                dec_neg = 1'b1;
                dec_ovf = (bus.i_argA == MIN_NEG);
            end
            MODE_ABS: begin
                dec_neg = arg_msb;
                dec_ovf = (bus.i_argA == MIN_NEG);
            end
            MODE_SM2TC: begin
                dec_neg        = arg_msb;
                dec_op[NUM-1]  = 1'b0;
            end
            default: begin
                dec_neg = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sr_d       = sr_q;
        neg_d      = neg_q;
        ovf_pend_d = ovf_pend_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        full_res   = {cell_bit, sr_q[NUM-1:1]};

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = dec_op;
                    neg_d      = dec_neg;
                    ovf_pend_d = dec_ovf;
                    cnt_d      = '0;
                    sr_d       = '0;
                    ovf_d      = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                op_d  = {1'b0, op_q[NUM-1:1]};
                sr_d  = full_res;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef CHANGE_SEQ_SAT_EN
                    res_d = sat_result(full_res, ovf_pend_q);
`else
                    res_d = full_res;
`endif
                    ovf_d   = ovf_pend_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            sr_q       <= '0;
            neg_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sr_q       <= sr_d;
            neg_q      <= neg_d;
            ovf_pend_q <= ovf_pend_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = res_q;
    assign bus.o_ovf    = ovf_q;

endmodule

// File: tb/tb_change_seq.sv
// Directed bench for change_seq at NUM=4: vector table plus back-pressure
// and mid-operation reset sequences.
module tb_change_seq;
    import change_pkg::*;

    localparam int NUM = 4;

`ifdef CHANGE_SEQ_SAT_EN
    localparam logic [3:0] OVF_RES = 4'b0111;
`else
    localparam logic [3:0] OVF_RES = 4'b1000;
`endif

    typedef struct {
        logic [1:0] mode;
        logic [3:0] arg;
        logic [3:0] res;
        logic       ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    change_seq_if #(.NUM(NUM)) bus ();

    change_seq #(.NUM(NUM)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [3:0] arg,
                          input logic [3:0] exp_res, input logic exp_ovf,
                          input string nm);
        int w;
        int lat;
        w = 0;
        while (!bus.o_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({nm, " ready_before"}, bus.o_ready, 1);
        bus.i_valid = 1'b1;
        bus.i_argA  = arg;
        bus.i_mode  = mode;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_argA  = ~arg;
        bus.i_mode  = ~mode;
        chk({nm, " ready_after_accept"}, bus.o_ready, 0);
        lat = 0;
        while (!bus.o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " result"}, bus.o_result, exp_res);
        chk({nm, " ovf"}, bus.o_ovf, exp_ovf);
        chk({nm, " ready_in_done"}, bus.o_ready, 0);
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        chk({nm, " valid_after_hs"}, bus.o_valid, 0);
        chk({nm, " ready_after_hs"}, bus.o_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int   w;

        vecs[0]  = '{MODE_NEG,   4'b0010, 4'b1110, 1'b0};
        vecs[1]  = '{MODE_ABS,   4'b1101, 4'b0011, 1'b0};
        vecs[2]  = '{MODE_ABS,   4'b0101, 4'b0101, 1'b0};
        vecs[3]  = '{MODE_NEG,   4'b1000, OVF_RES, 1'b1};
        vecs[4]  = '{MODE_ABS,   4'b1000, OVF_RES, 1'b1};
        vecs[5]  = '{MODE_SM2TC, 4'b1011, 4'b1101, 1'b0};
        vecs[6]  = '{MODE_SM2TC, 4'b1000, 4'b0000, 1'b0};
        vecs[7]  = '{MODE_SM2TC, 4'b0011, 4'b0011, 1'b0};
        vecs[8]  = '{MODE_PASS,  4'b1111, 4'b1111, 1'b0};
        vecs[9]  = '{MODE_PASS,  4'b1000, 4'b1000, 1'b0};
        vecs[10] = '{MODE_NEG,   4'b0000, 4'b0000, 1'b0};
        vecs[11] = '{MODE_NEG,   4'b0111, 4'b1001, 1'b0};
        vecs[12] = '{MODE_NEG,   4'b0001, 4'b1111, 1'b0};

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_argA  = '0;
        bus.i_mode  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", bus.o_ready, 0);
        chk("reset valid", bus.o_valid, 0);
        chk("reset result", bus.o_result, 0);
        chk("reset ovf", bus.o_ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", bus.o_ready, 0);
        @(posedge clk); #1;
        chk("ready_first_edge", bus.o_ready, 1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].mode, vecs[i].arg, vecs[i].res, vecs[i].ovf,
                   $sformatf("vec%0d", i));
        end

        // Back-pressure: hold DONE with i_ready low while inputs wiggle.
        bus.i_valid = 1'b1;
        bus.i_argA  = 4'b0011;
        bus.i_mode  = MODE_NEG;
        @(posedge clk); #1;
        w = 0;
        while (!bus.o_valid && w < 20) begin
            bus.i_argA = 4'($urandom);
            @(posedge clk); #1;
            w++;
        end
        chk("bp latency", w, 4);
        for (int k = 0; k < 5; k++) begin
            bus.i_argA = 4'($urandom);
            bus.i_mode = 2'($urandom);
            @(posedge clk); #1;
            chk($sformatf("bp valid c%0d", k), bus.o_valid, 1);
            chk($sformatf("bp result c%0d", k), bus.o_result, 4'b1101);
            chk($sformatf("bp ready c%0d", k), bus.o_ready, 0);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        chk("bp ready_after", bus.o_ready, 1);
        chk("bp valid_after", bus.o_valid, 0);

        // Reset two bits into an operation, then a clean operation.
        bus.i_valid = 1'b1;
        bus.i_argA  = 4'b0101;
        bus.i_mode  = MODE_NEG;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst ready", bus.o_ready, 0);
        chk("midrst valid", bus.o_valid, 0);
        chk("midrst result", bus.o_result, 0);
        chk("midrst ovf", bus.o_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst ready_release", bus.o_ready, 1);
        run_op(MODE_NEG, 4'b0001, 4'b1111, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
